// File: rtl/regfile_fwd.sv
// Register file with decode-stage operand forwarding, sticky halt and retire counter.
// Optional macro REGFILE_DBG_EN exposes the flattened register contents on dbg_regs.
module regfile_fwd #(
    parameter int                DATA_W   = 64,
    parameter int                NREG     = 15,
    parameter logic [DATA_W-1:0] RSP_INIT = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_rA,
    input  logic [3:0]        D_rB,
    input  logic [DATA_W-1:0] D_valP,
    input  logic [3:0]        e_dstE,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [2:0]        W_stat,
    input  logic [3:0]        W_icode,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic [3:0]        d_dstE,
    output logic [3:0]        d_dstM,
    output logic [DATA_W-1:0] d_valA,
    output logic [DATA_W-1:0] d_valB,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
`ifdef REGFILE_DBG_EN
    ,
    output logic [NREG*DATA_W-1:0] dbg_regs
`endif
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [2:0] AOK   = 3'd1;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_en;

    // Unmapped ids (F or beyond NREG) fall through the loop and read as zero.
    function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] id);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (id == 4'(i)) v = regs[i];
        end
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] fwd_val(input logic [3:0] src);
        if (src == RNONE)       return '0;
        else if (src == e_dstE) return e_valE;
        else if (src == M_dstM) return m_valM;
        else if (src == M_dstE) return M_valE;
        else if (src == W_dstM) return W_valM;
        else if (src == W_dstE) return W_valE;
        else                    return rf_read(src);
    endfunction

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            4'h2, 4'h4, 4'h6, 4'hA: d_srcA = D_rA;
            4'h9, 4'hB:             d_srcA = RSP;
            default: ;
        endcase
        case (D_icode)
            4'h4, 4'h5, 4'h6:       d_srcB = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: d_srcB = RSP;
            default: ;
        endcase
        case (D_icode)
            4'h2, 4'h3, 4'h6:       d_dstE = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: d_dstE = RSP;
            default: ;
        endcase
        case (D_icode)
            4'h5, 4'hB: d_dstM = D_rA;
            default: ;
        endcase
    end

    // Calls and jumps carry valP through valA, bypassing any forwarding hit.
    always_comb begin
        d_valA = '0;
        if (D_icode == 4'h7 || D_icode == 4'h8) d_valA = D_valP;
        else                                    d_valA = fwd_val(d_srcA);
        d_valB = fwd_val(d_srcB);
    end

    assign wr_en = (W_stat == AOK) && !halted;

    // Writeback: valM wins over valE when both target the same register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!rst_n) begin
                regs[i] <= (i == 4) ? RSP_INIT : '0;
            end else if (wr_en) begin
                if (W_dstM == 4'(i))      regs[i] <= W_valM;
                else if (W_dstE == 4'(i)) regs[i] <= W_valE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted  <= 1'b0;
            retired <= '0;
        end else begin
            if (W_stat != AOK) halted <= 1'b1;
            if (wr_en && W_icode != 4'h0 && W_icode != 4'h1 && retired != '1)
                retired <= retired + CNT_W'(1);
        end
    end

`ifdef REGFILE_DBG_EN
    for (genvar g = 0; g < NREG; g++) begin : g_dbg
        assign dbg_regs[g*DATA_W +: DATA_W] = regs[g];
    end
`endif

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed self-checking bench for regfile_fwd: reset, writeback, forwarding priority, halt.
module tb_regfile_fwd;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        D_icode, D_rA, D_rB;
    logic [DATA_W-1:0] D_valP;
    logic [3:0]        e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [DATA_W-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [2:0]        W_stat;
    logic [3:0]        W_icode;
    logic [3:0]        d_srcA, d_srcB, d_dstE, d_dstM;
    logic [DATA_W-1:0] d_valA, d_valB;
    logic              halted;
    logic [CNT_W-1:0]  retired;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_fwd #(
        .DATA_W(DATA_W), .NREG(15), .RSP_INIT(64'h100), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .D_rA(D_rA), .D_rB(D_rB), .D_valP(D_valP),
        .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM),
        .W_valE(W_valE), .W_valM(W_valM),
        .W_stat(W_stat), .W_icode(W_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_valA(d_valA), .d_valB(d_valB),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bypass();
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF;
        W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
        W_icode = 4'h0; W_stat = 3'd1;
    endtask

    // Read register r through port A using an rrmovq-style decode (icode 2).
    task automatic read_a(input logic [3:0] r, input string tag, input logic [63:0] exp);
        D_icode = 4'h2; D_rA = r; D_rB = 4'hF;
        #1;
        check(tag, d_valA, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        D_icode = 4'h0; D_rA = 4'hF; D_rB = 4'hF; D_valP = '0;
        clear_bypass();
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        D_icode = 4'h9; #1;
        check("rst_srcA_rsp", d_srcA, 4'h4);
        check("rst_rsp", d_valA, 64'h100);
        read_a(4'h1, "rst_rcx", 64'h0);
        check("rst_halted", halted, 1'b0);
        check("rst_retired", retired, 0);
        D_icode = 4'h6; D_rA = 4'h0; D_rB = 4'h3; #1;
        check("opq_dstE", d_dstE, 4'h3);
        check("opq_dstM", d_dstM, 4'hF);
        check("opq_valB", d_valB, 64'h0);

        // Writeback with one-cycle latency, no write-through before the edge
        W_dstE = 4'h2; W_valE = 64'h5; W_icode = 4'h6;
        D_icode = 4'h2; D_rA = 4'h2; D_rB = 4'hF; #1;
        check("wb_fwd_prior", d_valA, 64'h5);
        tick();
        clear_bypass();
        read_a(4'h2, "wb_rdx", 64'h5);
        check("wb_retired", retired, 1);

        // Forwarding priority on srcA and srcB
        D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h3;
        e_dstE = 4'h3; e_valE = 64'h1;
        M_dstM = 4'h3; m_valM = 64'h2;
        W_dstE = 4'h3; W_valE = 64'h3;
        #1;
        check("fwd_e", d_valA, 64'h1);
        check("fwd_e_B", d_valB, 64'h1);
        e_dstE = 4'hF; #1;
        check("fwd_mM", d_valA, 64'h2);
        M_dstM = 4'hF; M_dstE = 4'h3; M_valE = 64'h7;
        W_dstM = 4'h3; W_valM = 64'h9; #1;
        check("fwd_ME", d_valA, 64'h7);
        M_dstE = 4'hF; #1;
        check("fwd_WM", d_valB, 64'h9);
        W_dstM = 4'hF; #1;
        check("fwd_WE", d_valA, 64'h3);
        clear_bypass();
        e_dstE = 4'hF; e_valE = 64'hDEAD; D_icode = 4'h0; #1;
        check("no_fwd_srcF", d_valA, 64'h0);
        clear_bypass();

        // popq rsp: valM wins over valE
        W_dstE = 4'h4; W_dstM = 4'h4; W_valE = 64'h108; W_valM = 64'h55; W_icode = 4'hB;
        tick();
        clear_bypass();
        read_a(4'h4, "popq_rsp", 64'h55);
        check("popq_retired", retired, 2);

        // call: valA is valP despite bypass hits
        D_icode = 4'h8; D_rA = 4'h5; D_rB = 4'h5; D_valP = 64'h1234;
        e_dstE = 4'h5; e_valE = 64'hAA; M_dstM = 4'h4; m_valM = 64'h77; #1;
        check("call_valA", d_valA, 64'h1234);
        check("call_srcB", d_srcB, 4'h4);
        check("call_dstE", d_dstE, 4'h4);
        check("call_valB", d_valB, 64'h77);
        clear_bypass();

        // Halt: write suppressed, later writes and counts frozen
        W_stat = 3'd2; W_dstE = 4'h1; W_valE = 64'h99; W_icode = 4'h6;
        tick();
        W_dstE = 4'hF;
        read_a(4'h1, "hlt_rcx", 64'h0);
        check("hlt_halted", halted, 1'b1);
        check("hlt_retired", retired, 2);
        W_stat = 3'd1; W_dstE = 4'h1; W_valE = 64'h42; W_icode = 4'h6;
        tick();
        clear_bypass();
        read_a(4'h1, "hlt_after_rcx", 64'h0);
        check("hlt_after_halted", halted, 1'b1);
        check("hlt_after_retired", retired, 2);

        // Reset mid-program beats a concurrent write
        rst_n = 1'b0;
        W_dstE = 4'h2; W_valE = 64'hAA; W_icode = 4'h6;
        tick();
        rst_n = 1'b1;
        clear_bypass();
        read_a(4'h2, "mid_rst_rdx", 64'h0);
        read_a(4'h4, "mid_rst_rsp", 64'h100);
        check("mid_rst_halted", halted, 1'b0);
        check("mid_rst_retired", retired, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_fwd.md
REGFILE_FWD -- requirements
Module: regfile_fwd

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register and datapath width in bits.
REQ-002 SHALL have parameter NREG, default 15, number of architectural registers, range 1..15; ids 0..NREG-1 are valid.
REQ-003 SHALL have parameter RSP_INIT, default 0, reset value of register 4 (rsp); applies only when NREG>4.
REQ-004 SHALL have parameter CNT_W, default 32, width of the retire counter.
REQ-005 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have D_icode  input  4  decode-stage instruction code.
REQ-008 SHALL have D_rA, D_rB  input  4 each  decode-stage register specifiers.
REQ-009 SHALL have D_valP  input  DATA_W  decode-stage incremented PC.
REQ-010 SHALL have e_dstE, M_dstE, M_dstM, W_dstE, W_dstM  input  4 each  bypass destination ids; 4'hF = none.
REQ-011 SHALL have e_valE, M_valE, m_valM, W_valE, W_valM  input  DATA_W each  bypass and writeback values.
REQ-012 SHALL have W_stat  input  3  writeback status (1 AOK, 2 HLT, 3 ADR, 4 INS).
REQ-013 SHALL have W_icode  input  4  writeback instruction code.
REQ-014 SHALL have d_srcA, d_srcB, d_dstE, d_dstM  output  4 each  decoded register ids.
REQ-015 SHALL have d_valA, d_valB  output  DATA_W each  forwarded operands.
REQ-016 SHALL have halted  output  1  sticky halt flag.
REQ-017 SHALL have retired  output  CNT_W  retired-instruction count.

Function
REQ-018 SHALL set d_srcA = D_rA for icode 2,4,6,A; 4 for icode 9,B; else F.
REQ-019 SHALL set d_srcB = D_rB for icode 4,5,6; 4 for icode 8,9,A,B; else F.
REQ-020 SHALL set d_dstE = D_rB for icode 2,3,6; 4 for icode 8,9,A,B; else F; d_dstM = D_rA for icode 5,B; else F.
REQ-021 SHALL drive d_valA = D_valP for icode 7 or 8, regardless of forwarding.
REQ-022 SHALL otherwise forward with fixed priority e_dstE > M_dstM > M_dstE > W_dstM > W_dstE, else register-file read; same rule for d_valB.
REQ-023 SHALL never forward or match when the source id is F; source F or id >= NREG reads as 0.
REQ-024 SHALL make register reads combinational and return pre-edge contents (no internal write-through).
REQ-025 SHALL on a rising edge with W_stat==AOK and halted==0 write W_valE to W_dstE and W_valM to W_dstM; ids F or >= NREG are ignored.
REQ-026 SHALL, when W_dstE==W_dstM (valid), store W_valM only.
REQ-027 SHALL set halted on the first edge where W_stat != AOK; the write of that cycle is suppressed, and halted stays set until reset.
REQ-028 SHALL increment retired on each edge with W_stat==AOK, halted==0 and W_icode not 0 or 1; saturate at all-ones.
REQ-029 SHALL keep all decode outputs purely combinational (zero latency); writeback has one-cycle latency to the register file.

Reset
REQ-030 SHALL, on a rising edge with rst_n==0, clear all registers to 0 except register 4 = RSP_INIT, clear halted, and clear retired.
REQ-031 SHALL give reset priority over any write or count in the same cycle, including mid-program.

Configuration
REQ-032 SHALL, with REGFILE_DBG_EN defined, add output dbg_regs [NREG*DATA_W-1:0], register i at bits [i*DATA_W +: DATA_W], reflecting current contents.
REQ-033 SHALL, without REGFILE_DBG_EN, omit dbg_regs; all other behaviour is identical.

Verification
REQ-034 SHALL cover: reset with RSP_INIT=0x100 -> rsp reads 0x100, other regs 0, halted=0, retired=0.
REQ-035 SHALL cover: W_dstE=2, W_valE=5, AOK, then read rA=2 via icode 2 with no bypass -> d_valA=5 one cycle later.
REQ-036 SHALL cover: d_srcA=3 with e_dstE=3 (val 1), M_dstM=3 (val 2), W_dstE=3 (val 3) -> d_valA=1; remove e -> 2.
REQ-037 SHALL cover: popq rsp with W_dstE=W_dstM=4, valE=0x108, valM=0x55 -> rsp=0x55.
REQ-038 SHALL cover: W_stat=HLT with W_dstE=1 -> rcx unchanged, halted=1; later AOK writes ignored and retired frozen.
REQ-039 SHALL cover: icode 8 with bypass hits on rA -> d_valA=D_valP; d_srcB=4, d_dstE=4.
